// File: rtl/seq_gen_00_10_11_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_00_10_11_if
//  Description : Control and symbol bundle between a stimulus controller
//                (master) and the 00->10->11 stimulus generator (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_gen_00_10_11_if;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic       x2;
  logic       x1;
  logic       busy;
  logic       done;
  logic [1:0] sym_idx;
  logic       expect_z;

  modport master (
    output start, stop, mode,
    input  x2, x1, busy, done, sym_idx, expect_z
  );

  modport slave (
    input  start, stop, mode,
    output x2, x1, busy, done, sym_idx, expect_z
  );
endinterface
`default_nettype wire

// File: rtl/seq_gen_00_10_11.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_00_10_11
//  Description : Stimulus transmitter for the 00->10->11 sequence detector.
//                Emits a mode-selected symbol sequence on {x2,x1}, holding
//                each symbol HOLD_CYCLES cycles, flags where z must be 1 and
//                pulses done after normal completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen_00_10_11 #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 24
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  seq_gen_00_10_11_if.slave  sg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_term = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]       r_mode,  w_mode_nxt;
  logic [1:0]       r_idx,   w_idx_nxt;
  logic [1:0]       r_x,     w_x_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
  logic             r_ez,    w_ez_nxt;
  logic [1:0]       w_last;

  // Symbol table: {x2,x1} for a given mode and position in the sequence.
  function automatic logic [1:0] symbol(input logic [1:0] mode, input logic [1:0] idx);
    logic [1:0] s;
    s = 2'b00;
    case (mode)
      2'd0, 2'd2: case (idx)
                    2'd1:    s = 2'b10;
                    2'd2:    s = 2'b11;
                    default: s = 2'b00;
                  endcase
      2'd1:       case (idx)
                    2'd1:    s = 2'b10;
                    2'd2:    s = 2'b01;
                    default: s = 2'b00;
                  endcase
      default:    case (idx)
                    2'd1:    s = 2'b01;
                    2'd2:    s = 2'b11;
                    2'd3:    s = 2'b10;
                    default: s = 2'b00;
                  endcase
    endcase
    return s;
  endfunction

  // Next-state logic; outputs are precomputed from the next state so that
  // every output leaves a flop aligned with the symbol it describes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_idx_nxt   = r_idx;
    w_last      = (r_mode == 2'd3) ? 2'd3 : 2'd2;

    case (r_state)
      IDLE: begin
        if (sg.start && !sg.stop) begin
          w_state_nxt = EMIT;
          w_mode_nxt  = sg.mode;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end
      end
      EMIT: begin
        if (sg.stop) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_term) begin
          w_cnt_nxt = '0;
          if (r_idx == w_last) begin
            // Looping mode rewinds with no gap; the others finish.
            w_idx_nxt = 2'd0;
            if (r_mode != 2'd2) begin
              w_state_nxt = DONE;
            end
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == EMIT);
    w_done_nxt = (w_state_nxt == DONE);
    w_x_nxt    = w_busy_nxt ? symbol(w_mode_nxt, w_idx_nxt) : 2'b00;
    // Only modes 0 and 2 (bit0 clear) form the valid 00->10->11 pattern.
    w_ez_nxt   = w_busy_nxt && !w_mode_nxt[0] && (w_idx_nxt == 2'd2);
  end

  // State, counter and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= 2'd0;
      r_idx   <= 2'd0;
      r_x     <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ez    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_idx   <= w_idx_nxt;
      r_x     <= w_x_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ez    <= w_ez_nxt;
    end
  end

  assign sg.x2       = r_x[1];
  assign sg.x1       = r_x[0];
  assign sg.busy     = r_busy;
  assign sg.done     = r_done;
  assign sg.sym_idx  = r_idx;
  assign sg.expect_z = r_ez;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen_00_10_11.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_gen_00_10_11
//  Description : Directed bench for seq_gen_00_10_11. Instance A uses
//                HOLD_CYCLES=2, instance B uses HOLD_CYCLES=1. Observed
//                word is {x2,x1,busy,done,expect_z,sym_idx[1:0]}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_gen_00_10_11;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_gen_00_10_11_if ifa ();
  seq_gen_00_10_11_if ifb ();

  seq_gen_00_10_11 #(.HOLD_CYCLES(2), .CNT_W(24)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .sg    (ifa)
  );

  seq_gen_00_10_11 #(.HOLD_CYCLES(1), .CNT_W(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .sg    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs_a();
    return {ifa.x2, ifa.x1, ifa.busy, ifa.done, ifa.expect_z, ifa.sym_idx};
  endfunction

  function automatic logic [6:0] obs_b();
    return {ifb.x2, ifb.x1, ifb.busy, ifb.done, ifb.expect_z, ifb.sym_idx};
  endfunction

  // Advance one edge and sample 1 ns later: the sample is that cycle's value.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.start = 1'b1; ifa.stop = 1'b0; ifa.mode = 2'd2;
    ifb.start = 1'b1; ifb.stop = 1'b0; ifb.mode = 2'd0;
    tick(); tick();
    checks++;
    if (obs_a() !== 7'b0) begin
      failures++;
      $display("FAIL reset_a got=%b exp=%b", obs_a(), 7'b0);
    end
    checks++;
    if (obs_b() !== 7'b0) begin
      failures++;
      $display("FAIL reset_b got=%b exp=%b", obs_b(), 7'b0);
    end
    ifa.start = 1'b0; ifb.start = 1'b0; ifa.mode = 2'd0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mode0();
    logic [6:0] ex [8];
    ex = '{7'b0010000, 7'b0010000, 7'b1010001, 7'b1010001,
           7'b1110110, 7'b1110110, 7'b0001000, 7'b0000000};
    ifa.mode = 2'd0; ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (obs_a() !== ex[c]) begin
        failures++;
        $display("FAIL mode0 cycle=%0d got=%b exp=%b", c + 1, obs_a(), ex[c]);
      end
      if (c < 7) tick();
    end
  endtask

  task automatic test_mode1();
    logic [6:0] ex [8];
    ex = '{7'b0010000, 7'b0010000, 7'b1010001, 7'b1010001,
           7'b0110010, 7'b0110010, 7'b0001000, 7'b0000000};
    ifa.mode = 2'd1; ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (obs_a() !== ex[c]) begin
        failures++;
        $display("FAIL mode1 cycle=%0d got=%b exp=%b", c + 1, obs_a(), ex[c]);
      end
      if (c < 7) tick();
    end
  endtask

  task automatic test_mode3_hold1();
    logic [6:0] ex [6];
    ex = '{7'b0010000, 7'b0110001, 7'b1110010, 7'b1010011,
           7'b0001000, 7'b0000000};
    ifb.mode = 2'd3; ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (obs_b() !== ex[c]) begin
        failures++;
        $display("FAIL mode3_hold1 cycle=%0d got=%b exp=%b", c + 1, obs_b(), ex[c]);
      end
      if (c < 5) tick();
    end
  endtask

  task automatic test_mode0_hold1();
    logic [6:0] ex [5];
    ex = '{7'b0010000, 7'b1010001, 7'b1110110, 7'b0001000, 7'b0000000};
    ifb.mode = 2'd0; ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs_b() !== ex[c]) begin
        failures++;
        $display("FAIL mode0_hold1 cycle=%0d got=%b exp=%b", c + 1, obs_b(), ex[c]);
      end
      if (c < 4) tick();
    end
  endtask

  task automatic test_mode2_stop();
    logic [6:0] ex [10];
    ex = '{7'b0010000, 7'b0010000, 7'b1010001, 7'b1010001,
           7'b1110110, 7'b1110110, 7'b0010000, 7'b0010000,
           7'b1010001, 7'b0000000};
    ifa.mode = 2'd2; ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs_a() !== ex[c]) begin
        failures++;
        $display("FAIL mode2_stop cycle=%0d got=%b exp=%b", c + 1, obs_a(), ex[c]);
      end
      if (c == 8) ifa.stop = 1'b1;
      if (c < 9) tick();
    end
    ifa.stop = 1'b0;
    tick();
    checks++;
    if (obs_a() !== 7'b0) begin
      failures++;
      $display("FAIL mode2_after_stop got=%b exp=%b", obs_a(), 7'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ex [9];
    ex = '{7'b0010000, 7'b0010000, 7'b1010001, 7'b1010001,
           7'b1110110, 7'b1110110, 7'b0001000, 7'b0000000,
           7'b0010000};
    ifa.mode = 2'd0; ifa.start = 1'b1;
    tick();
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (obs_a() !== ex[c]) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d got=%b exp=%b", c + 1, obs_a(), ex[c]);
      end
      if (c == 1) ifa.mode = 2'd1;
      if (c < 8) tick();
    end
    ifa.stop = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
        failures++;
        $display("FAIL stop_with_start step=%0d busy=%b done=%b exp=0/0", c, ifa.busy, ifa.done);
      end
    end
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.mode = 2'd0;
    tick();
  endtask

  task automatic test_start_stop();
    ifb.mode = 2'd0; ifb.start = 1'b1; ifb.stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs_b() !== 7'b0) begin
        failures++;
        $display("FAIL start_stop step=%0d got=%b exp=%b", c, obs_b(), 7'b0);
      end
    end
    ifb.start = 1'b0; ifb.stop = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [6:0] ex [7];
    ex = '{7'b0010000, 7'b0010000, 7'b1010001, 7'b1010001,
           7'b1110110, 7'b1110110, 7'b0001000};
    ifa.mode = 2'd0; ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs_a() !== 7'b0) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=%b", obs_a(), 7'b0);
    end
    rst_n = 1'b1;
    tick();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (obs_a() !== ex[c]) begin
        failures++;
        $display("FAIL after_reset cycle=%0d got=%b exp=%b", c + 1, obs_a(), ex[c]);
      end
      if (c < 6) tick();
    end
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.mode = 2'd0;
    ifb.start = 1'b0; ifb.stop = 1'b0; ifb.mode = 2'd0;
    test_reset();
    test_mode0();
    test_mode1();
    test_mode3_hold1();
    test_mode0_hold1();
    test_mode2_stop();
    test_back_to_back();
    test_start_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
